// File: rtl/mips_mc_datapath_regs.sv
// mips_mc_datapath_regs
//
// Register stage of the multicycle MIPS32 core. It holds PC, IR, MDR, A, B and
// ALUOut, along with a fetch counter. It also steers the memory port, the ALU
// operand buses and the register-file ports from the control strobes of the
// sequencing FSM. The ALU and register file sit outside this block. Sequencing
// belongs entirely to the FSM, so this block has no state machine.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   IorD .. MemWrite    : control strobes from the FSM
//   mem_rdata           : memory read data
//   alu_result/alu_zero : ALU result and zero flag
//   rf_rd1/rf_rd2       : register-file read data
//   opcode/funct        : IR fields returned to the FSM
//   mem_addr/mem_wdata/mem_we : memory port
//   alu_srca/alu_srcb   : ALU operands
//   rf_ra1/rf_ra2/rf_wa/rf_wd/rf_we : register-file ports
//   pc, instr_count     : current PC, number of fetches (IRWrite cycles)
//
// Only WIDTH = 32 is meaningful. The jump target and the immediate fields
// assume the MIPS32 instruction layout.

module mips_mc_datapath_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IorD,
    input  logic             AluSrcA,
    input  logic [1:0]       AluSrcB,
    input  logic             IRWrite,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic [1:0]       PCSrc,
    input  logic             RegDst,
    input  logic             MemtoReg,
    input  logic             RegWrite,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic [WIDTH-1:0] rf_rd1,
    input  logic [WIDTH-1:0] rf_rd2,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [4:0]       rf_ra1,
    output logic [4:0]       rf_ra2,
    output logic [4:0]       rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic             rf_we,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr_count
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] mdr_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] aluout_q;
    logic [WIDTH-1:0] instr_count_q;

    logic             taken;
    logic             pc_en;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] imm;

    assign imm = {{16{ir_q[15]}}, ir_q[15:0]};

    // Only beq/bne can take a branch. Branch on any other opcode does nothing.
    always_comb begin
        taken = 1'b0;
        case (ir_q[31:26])
            OP_BEQ:  taken = alu_zero;
            OP_BNE:  taken = ~alu_zero;
            default: taken = 1'b0;
        endcase
    end

    assign pc_en = PCWrite | (Branch & taken);

    // The reserved encoding 3 reloads the current PC, so an enabled write holds.
    always_comb begin
        pc_next = pc_q;
        case (PCSrc)
            2'd0:    pc_next = alu_result;
            2'd1:    pc_next = aluout_q;
            2'd2:    pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
            default: pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            mdr_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            aluout_q      <= '0;
            instr_count_q <= '0;
        end else begin
            mdr_q    <= mem_rdata;
            a_q      <= rf_rd1;
            b_q      <= rf_rd2;
            aluout_q <= alu_result;
            if (IRWrite) begin
                ir_q          <= mem_rdata;
                instr_count_q <= instr_count_q + 1'b1;
            end
            if (pc_en) begin
                pc_q <= pc_next;
            end
        end
    end

    always_comb begin
        alu_srcb = b_q;
        case (AluSrcB)
            2'd0:    alu_srcb = b_q;
            2'd1:    alu_srcb = 32'd4;
            2'd2:    alu_srcb = imm;
            default: alu_srcb = {imm[WIDTH-3:0], 2'b00};
        endcase
    end

    assign opcode      = ir_q[31:26];
    assign funct       = ir_q[5:0];
    assign mem_addr    = IorD ? aluout_q : pc_q;
    assign mem_wdata   = b_q;
    assign mem_we      = MemWrite;
    assign alu_srca    = AluSrcA ? a_q : pc_q;
    assign rf_ra1      = ir_q[25:21];
    assign rf_ra2      = ir_q[20:16];
    assign rf_wa       = RegDst ? ir_q[15:11] : ir_q[20:16];
    assign rf_wd       = MemtoReg ? mdr_q : aluout_q;
    assign rf_we       = RegWrite;
    assign pc          = pc_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_mc_datapath_regs.sv
module tb_mips_mc_datapath_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        IorD, AluSrcA, IRWrite, PCWrite, Branch, RegDst, MemtoReg, RegWrite, MemWrite;
    logic [1:0]  AluSrcB, PCSrc;
    logic [31:0] mem_rdata, alu_result, rf_rd1, rf_rd2;
    logic        alu_zero;
    logic [5:0]  opcode, funct;
    logic [31:0] mem_addr, mem_wdata, alu_srca, alu_srcb, rf_wd, pc, instr_count;
    logic        mem_we, rf_we;
    logic [4:0]  rf_ra1, rf_ra2, rf_wa;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mips_mc_datapath_regs #(.RESET_PC(32'h0000_0000), .WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .IorD(IorD), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .mem_rdata(mem_rdata), .alu_result(alu_result), .alu_zero(alu_zero),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .opcode(opcode), .funct(funct), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
        .pc(pc), .instr_count(instr_count)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_idle();
        IorD = 0; AluSrcA = 0; AluSrcB = 2'd0; IRWrite = 0; PCWrite = 0; Branch = 0;
        PCSrc = 2'd0; RegDst = 0; MemtoReg = 0; RegWrite = 0; MemWrite = 0;
    endtask

    initial begin
        strobes_idle();
        reset = 1; mem_rdata = 32'h0; alu_result = 32'h0; alu_zero = 0;
        rf_rd1 = 32'h0; rf_rd2 = 32'h0;
        step();
        check("reset_pc", pc, 32'h0);
        check("reset_opcode", {26'd0, opcode}, 32'h0);
        check("reset_funct", {26'd0, funct}, 32'h0);
        check("reset_count", instr_count, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);

        // fetch of addi $8,$0,5
        reset = 0;
        mem_rdata = 32'h2008_0005; alu_result = 32'h4; IRWrite = 1; PCWrite = 1; PCSrc = 2'd0;
        step();
        check("fetch_pc", pc, 32'h4);
        check("fetch_opcode", {26'd0, opcode}, 32'h8);
        check("fetch_count", instr_count, 32'h1);
        check("fetch_ra1", {27'd0, rf_ra1}, 32'h0);
        check("fetch_ra2", {27'd0, rf_ra2}, 32'h8);

        // IR holds without IRWrite
        IRWrite = 0; PCWrite = 0; mem_rdata = 32'hDEAD_BEEF; alu_result = 32'h99;
        step();
        check("ir_hold_opcode", {26'd0, opcode}, 32'h8);
        check("ir_hold_count", instr_count, 32'h1);
        check("ir_hold_pc", pc, 32'h4);

        // beq: load IR, ALUOut <= 0x10
        mem_rdata = 32'h1000_0003; alu_result = 32'h10; IRWrite = 1;
        step();
        IRWrite = 0; Branch = 1; PCSrc = 2'd1; alu_zero = 1; alu_result = 32'h24;
        step();
        check("beq_taken_pc", pc, 32'h10);
        alu_zero = 0;
        step();
        check("beq_not_taken_pc", pc, 32'h10);

        // bne: ALUOut <= 0x30
        Branch = 0; mem_rdata = 32'h1400_0003; alu_result = 32'h30; IRWrite = 1;
        step();
        IRWrite = 0; Branch = 1; alu_zero = 1;
        step();
        check("bne_zero_hold_pc", pc, 32'h10);
        alu_zero = 0; alu_result = 32'h44;
        step();
        check("bne_taken_pc", pc, 32'h30);

        // R-type add: Branch is ignored
        Branch = 0; mem_rdata = 32'h0000_0020; alu_result = 32'h50; IRWrite = 1;
        step();
        check("rtype_funct", {26'd0, funct}, 32'h20);
        IRWrite = 0; Branch = 1; alu_zero = 1;
        step();
        check("rtype_branch_hold_pc", pc, 32'h30);
        alu_zero = 0;
        step();
        check("rtype_branch_hold_pc2", pc, 32'h30);

        // jump: first set PC to 0x4000_0008 while loading j 0x100
        Branch = 0; PCWrite = 1; PCSrc = 2'd0; alu_result = 32'h4000_0008;
        mem_rdata = 32'h0800_0100; IRWrite = 1;
        step();
        check("jump_setup_pc", pc, 32'h4000_0008);
        IRWrite = 0; PCSrc = 2'd2; alu_result = 32'h7777_7777;
        step();
        check("jump_pc", pc, 32'h4000_0400);
        PCSrc = 2'd3;
        step();
        check("pcsrc3_hold_pc", pc, 32'h4000_0400);
        PCWrite = 0; PCSrc = 2'd0;

        // operand and load/store muxes; inputs held so registers stay stable
        mem_rdata = 32'h2108_FFFC; alu_result = 32'h100;
        rf_rd1 = 32'hAAAA_0000; rf_rd2 = 32'h5555_1234; IRWrite = 1;
        step();
        IRWrite = 0;
        check("count_before_wrap", instr_count, 32'h6);
        AluSrcB = 2'd3; #1 check("srcb_imm_sl2", alu_srcb, 32'hFFFF_FFF0);
        AluSrcB = 2'd2; #1 check("srcb_imm", alu_srcb, 32'hFFFF_FFFC);
        AluSrcB = 2'd1; #1 check("srcb_four", alu_srcb, 32'h4);
        AluSrcB = 2'd0; #1 check("srcb_b", alu_srcb, 32'h5555_1234);
        AluSrcA = 1;    #1 check("srca_a", alu_srca, 32'hAAAA_0000);
        AluSrcA = 0;    #1 check("srca_pc", alu_srca, 32'h4000_0400);
        IorD = 1;       #1 check("mem_addr_aluout", mem_addr, 32'h100);
        IorD = 0;       #1 check("mem_addr_pc", mem_addr, 32'h4000_0400);
        check("mem_wdata", mem_wdata, 32'h5555_1234);
        MemtoReg = 1; RegDst = 0; #1;
        check("rf_wd_mdr", rf_wd, 32'h2108_FFFC);
        check("rf_wa_rt", {27'd0, rf_wa}, 32'h8);
        MemtoReg = 0; RegDst = 1; #1;
        check("rf_wd_aluout", rf_wd, 32'h100);
        check("rf_wa_rd", {27'd0, rf_wa}, 32'h1F);
        RegWrite = 1; MemWrite = 1; #1;
        check("rf_we_on", {31'd0, rf_we}, 32'h1);
        check("mem_we_on", {31'd0, mem_we}, 32'h1);
        RegWrite = 0; MemWrite = 0; #1;
        check("rf_we_off", {31'd0, rf_we}, 32'h0);
        check("mem_we_off", {31'd0, mem_we}, 32'h0);

        // counter wrap
        @(negedge clk);
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1 release dut.instr_count_q;
        check("count_forced", instr_count, 32'hFFFF_FFFF);
        IRWrite = 1;
        step();
        check("count_wrap", instr_count, 32'h0);

        // reset mid-instruction wins over every enable
        reset = 1; PCWrite = 1; PCSrc = 2'd0; alu_result = 32'h1234; IRWrite = 1;
        mem_rdata = 32'hFFFF_FFFF; rf_rd1 = 32'h1111_1111; rf_rd2 = 32'h2222_2222;
        IorD = 1; AluSrcA = 1; AluSrcB = 2'd0; MemtoReg = 1;
        step();
        check("rst_mid_pc", pc, 32'h0);
        check("rst_mid_opcode", {26'd0, opcode}, 32'h0);
        check("rst_mid_count", instr_count, 32'h0);
        check("rst_mid_aluout", mem_addr, 32'h0);
        check("rst_mid_a", alu_srca, 32'h0);
        check("rst_mid_b", alu_srcb, 32'h0);
        check("rst_mid_mdr", rf_wd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
